// File: rtl/team_06_pkg.sv
// Shared types and constants for the per-sample audio scheduler.
package team_06_pkg;

    typedef enum logic {
        LIST = 1'b0,
        TALK = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        NORMAL  = 3'd0,
        ECHO    = 3'd1,
        REVERB  = 3'd2,
        TREMOLO = 3'd3,
        SOFT    = 3'd4
    } current_effect_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        PROC  = 3'd3,
        OUT   = 3'd4
    } sched_state_t;

    localparam logic [7:0] MIDPOINT = 8'd128;

    // Effects that consume a delayed tap from the ring buffer.
    function automatic logic is_tap(input current_effect_t e);
        return (e == ECHO) || (e == REVERB);
    endfunction

    // Effects that run on the dry sample alone (wet mirrors dry).
    function automatic logic is_dry_only(input current_effect_t e);
        return (e == TREMOLO) || (e == SOFT);
    endfunction

endpackage

// File: rtl/team_06_tick_gen.sv
// Audio-rate tick: one-cycle pulse every CLK_DIV clocks, first one CLK_DIV-1 cycles after reset.
module team_06_tick_gen
    import team_06_pkg::*;
#(
    parameter int unsigned CLK_DIV = 750
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_W'(CLK_DIV - 2));
            cnt  <= (cnt == CNT_W'(CLK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/team_06_sample_scheduler.sv
// Per-sample sequencer: capture, ring-buffer write, optional tap read,
// effect handshake and output strobe, once per audio tick.
module team_06_sample_scheduler
    import team_06_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 750,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned ECHO_DLY   = 3000,
    parameter int unsigned REVERB_DLY = 400,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              state,
    input  logic [2:0]        current_effect,
    input  logic              effect_en,
    input  logic              mute_tog,
    input  logic [7:0]        mic_aud,
    input  logic [7:0]        spk_aud,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              eff_start,
    output logic [2:0]        eff_sel,
    output logic [7:0]        eff_dry,
    output logic [7:0]        eff_wet,
    input  logic              eff_done,
    input  logic [7:0]        eff_result,
    output logic [7:0]        out_sample,
    output logic              out_valid,
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output logic              err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic              tick;
    sched_state_t      st;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill;
    logic [7:0]        dry;
    current_effect_t   sel;
    logic              en;
    logic [TW-1:0]     wait_cnt;

    logic [7:0]        dry_in_c;
    logic [ADDR_W-1:0] fill_inc_c;
    logic [ADDR_W-1:0] tap_dly_c;
    logic [ADDR_W-1:0] tap_addr_c;
    logic              expired_c;

    team_06_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Write-side bookkeeping; fill is judged after this sample's write lands.
    always_comb begin
        dry_in_c   = (state_t'(state) == TALK) ? mic_aud : spk_aud;
        fill_inc_c = (fill == '1) ? fill : fill + ADDR_W'(1);
        tap_dly_c  = (sel == ECHO) ? ADDR_W'(ECHO_DLY) : ADDR_W'(REVERB_DLY);
        tap_addr_c = wr_ptr - tap_dly_c;
        expired_c  = (wait_cnt == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            wr_ptr      <= '0;
            fill        <= '0;
            dry         <= '0;
            sel         <= NORMAL;
            en          <= 1'b0;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            eff_start   <= 1'b0;
            eff_sel     <= '0;
            eff_dry     <= '0;
            eff_wet     <= '0;
            out_sample  <= MIDPOINT;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
            err         <= 1'b0;
        end else begin
            eff_start <= 1'b0;
            out_valid <= 1'b0;
            wait_cnt  <= wait_cnt + TW'(1);

            // A tick that lands while a sample is in flight is dropped.
            if (tick && (st != IDLE) && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;

            case (st)
                IDLE: begin
                    if (tick) begin
                        dry       <= dry_in_c;
                        sel       <= current_effect_t'(current_effect);
                        en        <= effect_en;
                        eff_sel   <= current_effect;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= dry_in_c;
                        wait_cnt  <= '0;
                        busy      <= 1'b1;
                        st        <= WRITE;
                    end
                end

                WRITE: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        fill     <= fill_inc_c;
                        wait_cnt <= '0;
                        if (en && is_tap(sel) && (fill_inc_c > tap_dly_c)) begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= tap_addr_c;
                            st       <= READ;
                        end else if (en && (is_tap(sel) || is_dry_only(sel))) begin
                            eff_dry   <= dry;
                            eff_wet   <= is_tap(sel) ? MIDPOINT : dry;
                            eff_start <= 1'b1;
                            st        <= PROC;
                        end else begin
                            out_sample <= mute_tog ? MIDPOINT : dry;
                            out_valid  <= 1'b1;
                            st         <= OUT;
                        end
                    end else if (expired_c) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        st      <= IDLE;
                    end
                end

                READ: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        eff_dry   <= dry;
                        eff_wet   <= mem_rdata;
                        eff_start <= 1'b1;
                        wait_cnt  <= '0;
                        st        <= PROC;
                    end else if (expired_c) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        st      <= IDLE;
                    end
                end

                PROC: begin
                    if (eff_done) begin
                        out_sample <= mute_tog ? MIDPOINT : eff_result;
                        out_valid  <= 1'b1;
                        st         <= OUT;
                    end else if (expired_c) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                        st   <= IDLE;
                    end
                end

                OUT: begin
                    busy <= 1'b0;
                    st   <= IDLE;
                end

                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    st      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_team_06_sample_scheduler.sv
// Directed bench for the sample scheduler with a small RAM and effect-unit model.
module tb_team_06_sample_scheduler;
    import team_06_pkg::*;

    localparam int unsigned CLK_DIV    = 40;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned ECHO_DLY   = 4;
    localparam int unsigned REVERB_DLY = 2;
    localparam int unsigned TIMEOUT    = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              state = 1'b1;
    logic [2:0]        current_effect = 3'd0;
    logic              effect_en = 1'b0;
    logic              mute_tog = 1'b0;
    logic [7:0]        mic_aud = 8'd0;
    logic [7:0]        spk_aud = 8'd0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              eff_start;
    logic [2:0]        eff_sel;
    logic [7:0]        eff_dry;
    logic [7:0]        eff_wet;
    logic              eff_done;
    logic [7:0]        eff_result;
    logic [7:0]        out_sample;
    logic              out_valid;
    logic              busy;
    logic [7:0]        overrun_cnt;
    logic              err;

    logic wack_en = 1'b1;
    logic rack_en = 1'b1;
    logic done_en = 1'b1;
    logic pending;
    logic [7:0] ram [8];

    int checks = 0;
    int errors = 0;

    int wr_cnt = 0, rd_cnt = 0, st_cnt = 0, out_cnt = 0;
    int wr_addr_q = 0, wr_data_q = 0, rd_addr_q = 0;
    int dry_q = 0, wet_q = 0, out_q = 0;

    always #5 clk = ~clk;

    team_06_sample_scheduler #(
        .CLK_DIV    (CLK_DIV),
        .ADDR_W     (ADDR_W),
        .ECHO_DLY   (ECHO_DLY),
        .REVERB_DLY (REVERB_DLY),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .current_effect (current_effect),
        .effect_en      (effect_en),
        .mute_tog       (mute_tog),
        .mic_aud        (mic_aud),
        .spk_aud        (spk_aud),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .eff_start      (eff_start),
        .eff_sel        (eff_sel),
        .eff_dry        (eff_dry),
        .eff_wet        (eff_wet),
        .eff_done       (eff_done),
        .eff_result     (eff_result),
        .out_sample     (out_sample),
        .out_valid      (out_valid),
        .busy           (busy),
        .overrun_cnt    (overrun_cnt),
        .err            (err)
    );

    // Same-cycle RAM acknowledge, separately gated for writes and reads.
    assign mem_ack   = mem_req && (mem_we ? wack_en : rack_en);
    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ack) ram[mem_addr] <= mem_wdata;
    end

    // Effect unit: result = dry + wet (mod 256), done one cycle after start when enabled.
    always @(posedge clk) begin
        if (rst)            pending <= 1'b0;
        else if (eff_start) pending <= 1'b1;
        else if (eff_done)  pending <= 1'b0;
    end
    assign eff_done   = pending && done_en;
    assign eff_result = eff_dry + eff_wet;

    always @(negedge clk) begin
        if (mem_req && mem_ack && mem_we) begin
            wr_addr_q <= int'(mem_addr);
            wr_data_q <= int'(mem_wdata);
            wr_cnt    <= wr_cnt + 1;
        end
        if (mem_req && mem_ack && !mem_we) begin
            rd_addr_q <= int'(mem_addr);
            rd_cnt    <= rd_cnt + 1;
        end
        if (eff_start) begin
            dry_q  <= int'(eff_dry);
            wet_q  <= int'(eff_wet);
            st_cnt <= st_cnt + 1;
        end
        if (out_valid) begin
            out_q   <= int'(out_sample);
            out_cnt <= out_cnt + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int base;
        bit seen;
        base = out_cnt;
        seen = 1'b0;
        for (int i = 0; i < 150 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (out_cnt != base) seen = 1'b1;
        end
        check({tag, "_out_seen"}, int'(seen), 1);
    endtask

    int exp_wa  [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int exp_wet [10] = '{128, 128, 128, 128, 10, 20, 30, 40, 50, 60};
    int exp_ra  [10] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 5};
    int exp_out [10] = '{138, 148, 158, 168, 60, 80, 100, 120, 140, 160};

    initial begin
        int req_cyc, ov_cyc, req_len, rd_base, out_base;
        bit  fell, found;

        for (int i = 0; i < 8; i++) ram[i] = 8'd0;

        // Reset state and bypass timing
        state = 1'b1; mic_aud = 8'd200; spk_aud = 8'd50;
        apply_reset();
        check("rst_out_sample", int'(out_sample), 128);
        check("rst_mem_req", int'(mem_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_overrun", int'(overrun_cnt), 0);
        check("rst_out_valid", int'(out_valid), 0);

        req_cyc = 0; ov_cyc = 0;
        for (int n = 1; n <= 100 && ov_cyc == 0; n++) begin
            @(negedge clk);
            if (mem_req && req_cyc == 0) req_cyc = n;
            if (out_valid) begin
                ov_cyc = n;
                check("byp_out_sample", int'(out_sample), 200);
            end
        end
        #1;
        check("byp_req_cycle", req_cyc, 40);
        check("byp_valid_cycle", ov_cyc, 41);
        check("byp_wr_addr", wr_addr_q, 0);
        check("byp_wr_data", wr_data_q, 200);
        @(negedge clk);
        check("byp_valid_pulse", int'(out_valid), 0);
        check("byp_idle", int'(busy), 0);

        state = 1'b0;
        wait_out("byp2");
        check("byp2_wr_addr", wr_addr_q, 1);
        check("byp2_wr_data", wr_data_q, 50);
        check("byp2_out", out_q, 50);

        // Echo warm-up, steady state and ring wrap
        state = 1'b1; effect_en = 1'b1; current_effect = 3'd1; mic_aud = 8'd10;
        apply_reset();
        for (int n = 0; n < 10; n++) begin
            mic_aud = 8'(10 * (n + 1));
            rd_base = rd_cnt;
            wait_out($sformatf("echo%0d", n + 1));
            check($sformatf("echo%0d_wr_addr", n + 1), wr_addr_q, exp_wa[n]);
            check($sformatf("echo%0d_wr_data", n + 1), wr_data_q, 10 * (n + 1));
            check($sformatf("echo%0d_dry", n + 1), dry_q, 10 * (n + 1));
            check($sformatf("echo%0d_wet", n + 1), wet_q, exp_wet[n]);
            check($sformatf("echo%0d_reads", n + 1), rd_cnt - rd_base, (n >= 4) ? 1 : 0);
            if (n >= 4) check($sformatf("echo%0d_rd_addr", n + 1), rd_addr_q, exp_ra[n]);
            check($sformatf("echo%0d_out", n + 1), out_q, exp_out[n]);
        end

        current_effect = 3'd3; mic_aud = 8'd70;
        rd_base = rd_cnt;
        wait_out("trem");
        check("trem_wr_addr", wr_addr_q, 2);
        check("trem_wet", wet_q, 70);
        check("trem_reads", rd_cnt - rd_base, 0);
        check("trem_sel", int'(eff_sel), 3);
        check("trem_out", out_q, 140);

        effect_en = 1'b0; mute_tog = 1'b1; mic_aud = 8'd99;
        wait_out("mute");
        check("mute_wr_data", wr_data_q, 99);
        check("mute_out", out_q, 128);
        mute_tog = 1'b0; mic_aud = 8'd33;
        wait_out("unmute");
        check("unmute_out", out_q, 33);

        // Write timeout, overrun while waiting, address reuse
        effect_en = 1'b0; mic_aud = 8'd77; wack_en = 1'b0;
        apply_reset();
        out_base = out_cnt;
        req_cyc = 0; req_len = 0; fell = 1'b0;
        for (int n = 1; n <= 200 && !fell; n++) begin
            @(negedge clk);
            if (mem_req) begin
                if (req_cyc == 0) req_cyc = n;
                req_len++;
            end else if (req_cyc != 0) begin
                fell = 1'b1;
            end
        end
        #1;
        check("to_req_cycle", req_cyc, 40);
        check("to_req_len", req_len, 64);
        check("to_err", int'(err), 1);
        check("to_busy", int'(busy), 0);
        check("to_no_valid", out_cnt - out_base, 0);
        check("to_out_sample", int'(out_sample), 128);
        check("to_overrun", int'(overrun_cnt), 1);
        wack_en = 1'b1;
        wait_out("to_retry");
        check("to_retry_addr", wr_addr_q, 0);
        check("to_retry_out", out_q, 77);
        check("to_err_sticky", int'(err), 1);

        // Effect done withheld beyond one tick period
        effect_en = 1'b1; current_effect = 3'd3; mic_aud = 8'd60; done_en = 1'b0;
        apply_reset();
        out_base = out_cnt;
        found = 1'b0;
        for (int n = 1; n <= 100 && !found; n++) begin
            @(negedge clk);
            if (eff_start) found = 1'b1;
        end
        check("ovr_started", int'(found), 1);
        repeat (48) @(negedge clk);
        check("ovr_cnt", int'(overrun_cnt), 1);
        check("ovr_busy", int'(busy), 1);
        check("ovr_no_valid", out_cnt - out_base, 0);
        done_en = 1'b1;
        wait_out("ovr_done");
        check("ovr_out", out_q, 120);
        check("ovr_err", int'(err), 0);
        mic_aud = 8'd61;
        wait_out("ovr_next");
        check("ovr_next_out", out_q, 122);
        check("ovr_cnt_hold", int'(overrun_cnt), 1);

        // Reverb fill-up, then reset while a tap read is outstanding
        current_effect = 3'd2; mic_aud = 8'd5;
        apply_reset();
        wait_out("rev1");
        check("rev1_out", out_q, 133);
        mic_aud = 8'd15;
        wait_out("rev2");
        check("rev2_out", out_q, 143);
        rack_en = 1'b0; mic_aud = 8'd25;
        found = 1'b0;
        for (int n = 1; n <= 100 && !found; n++) begin
            @(negedge clk);
            if (mem_req && !mem_we) found = 1'b1;
        end
        check("rev3_in_read", int'(found), 1);
        check("rev3_rd_addr", int'(mem_addr), 0);
        check("rev3_pre_out", int'(out_sample), 143);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_req", int'(mem_req), 0);
        check("midrst_out", int'(out_sample), 128);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        rack_en = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
